// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Purpose  : Central stall/flush sequencer for the 5-stage pipeline
//             (IF, IF/ID, ID/EX, EX/MEM, MEM/WB). Detects load-use hazards,
//             applies branch-redirect flushes, freezes the pipe while data
//             memory is busy, and raises a sticky error if an access never
//             completes. Keeps saturating stall/flush counters for debug.
//  Ports    : clk, rst_n            - clock, synchronous active-low reset
//             id_rs1/id_rs2         - source registers of the ID instruction
//             id_use_rs1/id_use_rs2 - ID instruction actually reads rs1/rs2
//             ex_rd, ex_memread     - EX destination register / EX is a load
//             ex_branch_taken       - EX resolved a PC redirect
//             mem_req, mem_ready    - MEM stage access / memory completes
//             pc_we .. memwb_bubble - stage-register controls (combinational)
//             mem_timeout_err       - sticky timeout flag (registered)
//             stall_cnt, flush_cnt  - saturating performance counters
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_flush,
  output logic             exmem_we,
  output logic             memwb_bubble,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] ERR      = 2'd2;

  localparam logic [3:0]       c_TIMEOUT = 4'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  logic [1:0]       r_state;
  logic [3:0]       r_wait_cnt;
  logic             r_err;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [1:0]       w_state_next;
  logic [3:0]       w_wait_next;
  logic             w_load_use;
  logic             w_mem_stall;
  logic             w_in_err;
  logic             w_branch_apply;
  logic             w_lu_apply;
  logic             w_stall_evt;

  // Register x0 never creates a dependency; an unread source field is ignored.
  assign w_load_use = ex_memread && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

  // Once in MEM_WAIT the access is still outstanding, so mem_req is not
  // re-qualified; only mem_ready ends the wait.
  assign w_mem_stall = ((r_state == RUN) && mem_req && !mem_ready) ||
                       ((r_state == MEM_WAIT) && !mem_ready);

  assign w_in_err = (r_state == ERR);

  // A frozen EX keeps branch/load-use conditions alive, so they are simply
  // deferred while memory stalls. A taken branch flushes the dependent ID
  // instruction, which makes a simultaneous load-use stall unnecessary.
  assign w_branch_apply = !w_in_err && !w_mem_stall && ex_branch_taken;
  assign w_lu_apply     = !w_in_err && !w_mem_stall && !ex_branch_taken && w_load_use;
  assign w_stall_evt    = w_in_err || w_mem_stall || w_lu_apply;

  // Stage-register controls
  always_comb begin
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    ifid_flush   = 1'b0;
    idex_we      = 1'b1;
    idex_flush   = 1'b0;
    exmem_we     = 1'b1;
    memwb_bubble = 1'b0;
    if (!rst_n) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      ifid_flush   = 1'b1;
      idex_we      = 1'b0;
      idex_flush   = 1'b1;
      exmem_we     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (w_in_err || w_mem_stall) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      idex_we      = 1'b0;
      exmem_we     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (w_branch_apply) begin
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
    end else if (w_lu_apply) begin
      // Hold PC and IF/ID, inject one bubble into ID/EX; the load moves on.
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      idex_flush   = 1'b1;
    end
  end

  // Next-state / wait-counter logic
  always_comb begin
    w_state_next = r_state;
    w_wait_next  = r_wait_cnt;
    case (r_state)
      RUN: begin
        if (w_mem_stall) begin
          w_state_next = MEM_WAIT;
          w_wait_next  = 4'd1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          w_state_next = RUN;
          w_wait_next  = 4'd0;
        end else if (r_wait_cnt == c_TIMEOUT) begin
          w_state_next = ERR;
        end else begin
          w_wait_next  = r_wait_cnt + 4'd1;
        end
      end
      ERR: begin
        w_state_next = ERR;
      end
      default: begin
        w_state_next = RUN;
        w_wait_next  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_wait_cnt  <= 4'd0;
      r_err       <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_next;
      if (w_state_next == ERR) begin
        r_err <= 1'b1;
      end
      if (w_stall_evt && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
      end
      if (w_branch_apply && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
      end
    end
  end

  assign mem_timeout_err = r_err;
  assign stall_cnt       = r_stall_cnt;
  assign flush_cnt       = r_flush_cnt;

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline (IF, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Detects load-use hazards, applies branch-redirect flushes, and freezes the pipe while data memory is not ready.
- Flags a sticky error if a data-memory access never completes.
- Keeps saturating stall and flush counters for performance debug.

Parameters:
- MEM_TIMEOUT, 15: maximum consecutive MEM_WAIT cycles before entering ERR.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- id_rs1  in  5  source register 1 of the instruction in ID
- id_rs2  in  5  source register 2 of the instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  destination register of the instruction in EX
- ex_memread  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch or jump (PC redirect)
- mem_req  in  1  MEM stage holds a valid load or store
- mem_ready  in  1  data memory completes the access this cycle
- pc_we  out  1  PC register load enable
- ifid_we  out  1  IF/ID register enable
- ifid_flush  out  1  IF/ID register loads a NOP
- idex_we  out  1  ID/EX register enable
- idex_flush  out  1  ID/EX register loads a bubble (control bits 0)
- exmem_we  out  1  EX/MEM register enable
- memwb_bubble  out  1  MEM/WB register captures RegWrite=0, MemtoReg=0
- mem_timeout_err  out  1  sticky error flag
- stall_cnt  out  CNT_W  count of stalled cycles
- flush_cnt  out  CNT_W  count of branch flush events

Behaviour:
- State register, states RUN, MEM_WAIT, ERR. Wait counter is 4 bits wide, wide enough for MEM_TIMEOUT.
- Reset (rst_n=0 at a clk edge): state=RUN, wait counter=0, mem_timeout_err=0, stall_cnt=0, flush_cnt=0.
- While rst_n=0, the combinational outputs are forced to: all *_we=0, ifid_flush=1, idex_flush=1, memwb_bubble=1.
- Stage-control outputs are combinational from state and inputs, so they act in the same cycle. Counters and the error flag are registered.
- Default (no event): all *_we=1, both flushes=0, memwb_bubble=0.
- Priority, highest first: ERR > memory stall > branch flush > load-use stall.
- ERR: all *_we=0, memwb_bubble=1, mem_timeout_err=1. Leaves ERR only on reset.
- Memory stall: RUN with mem_req=1 and mem_ready=0, or MEM_WAIT with mem_ready=0.
  - Outputs: pc_we=ifid_we=idex_we=exmem_we=0, memwb_bubble=1, flushes=0.
  - Branch and load-use conditions are ignored; they persist because EX is frozen.
- RUN -> MEM_WAIT on a memory stall; wait counter is loaded with 1.
- MEM_WAIT with mem_ready=1: default outputs (pipe advances), next state RUN, wait counter cleared.
- MEM_WAIT with mem_ready=0: wait counter increments. When the counter equals MEM_TIMEOUT, the next state is ERR.
- RUN with mem_req=1 and mem_ready=1: zero-wait access, no stall.
- Branch flush (ex_branch_taken=1, no memory stall): pc_we=1, ifid_flush=1, idex_flush=1, other enables 1.
  - Load-use in the same cycle is suppressed, because the dependent ID instruction is flushed.
- Load-use condition: ex_memread=1, ex_rd!=0, and either (id_use_rs1=1 and id_rs1==ex_rd) or (id_use_rs2=1 and id_rs2==ex_rd).
  - Outputs: pc_we=0, ifid_we=0, idex_flush=1, exmem_we=1, memwb_bubble=0.
  - Exactly one bubble, since the load moves to MEM next cycle.
- stall_cnt: +1 in every cycle with a memory stall, a load-use stall, or state ERR. Saturates at all-ones.
- flush_cnt: +1 in every cycle the branch flush is applied. Saturates at all-ones.
- Reset asserted during MEM_WAIT or ERR returns to RUN next edge; counters clear.

Test Plan:
- Load-use: ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1, mem_req=0 -> one cycle with pc_we=0, ifid_we=0, idex_flush=1; stall_cnt 0->1; next cycle (ex_memread=0) all defaults.
- x0 / unused source: ex_memread=1, ex_rd=0, id_rs1=0 -> no stall. Also ex_rd=7, id_rs2=7 with id_use_rs2=0 -> no stall.
- Branch plus load-use in the same cycle: ex_branch_taken=1 with a matching load-use -> pc_we=1, ifid_flush=1, idex_flush=1; flush_cnt=1; stall_cnt unchanged.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 with ex_branch_taken=1 held throughout.
  - Stall cycles: all *_we=0 and memwb_bubble=1 for 3 cycles; stall_cnt=3.
  - Ready cycle: branch flush applied, flush_cnt=1, state RUN.
- Timeout: mem_req=1, mem_ready=0 held -> ERR entered after 15 MEM_WAIT cycles; mem_timeout_err=1 and stays set with mem_ready=1 applied; rst_n=0 for one edge clears it and returns state to RUN.
- Counter saturation (CNT_W=4): 20 load-use stall cycles -> stall_cnt holds 15.
